// File: rtl/counter_sequencer.sv
// Command-driven up/down/bounce counter with a programmable prescaler,
// limit and auto-reload, controlled over a valid/ready command port.
module counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_reload,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    state_t           st_q, st_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       sh_mode_q, sh_mode_d;
    logic [WIDTH-1:0] sh_lim_q, sh_lim_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic             sh_rl_q, sh_rl_d;

    logic acc, step, is_down, is_bounce, at_top, at_zero;

    assign cmd_ready = ~clear;
    assign acc       = cmd_valid & cmd_ready;
    assign step      = (st_q == RUN) && (div_q == sh_div_q);
    assign is_down   = (sh_mode_q == MODE_DOWN);
    assign is_bounce = (sh_mode_q == MODE_BOUNCE);
    assign at_top    = (cnt_q >= sh_lim_q);
    assign at_zero   = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (clear) begin
            st_q      <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            tc_q      <= 1'b0;
            div_q     <= '0;
            sh_mode_q <= '0;
            sh_lim_q  <= '0;
            sh_div_q  <= '0;
            sh_rl_q   <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            tc_q      <= tc_d;
            div_q     <= div_d;
            sh_mode_q <= sh_mode_d;
            sh_lim_q  <= sh_lim_d;
            sh_div_q  <= sh_div_d;
            sh_rl_q   <= sh_rl_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        tc_d      = 1'b0;
        div_d     = div_q;
        sh_mode_d = sh_mode_q;
        sh_lim_d  = sh_lim_q;
        sh_div_d  = sh_div_q;
        sh_rl_d   = sh_rl_q;

        if (st_q == RUN)
            div_d = step ? '0 : div_q + 1'b1;

        // A step is only applied when no command is accepted that cycle
        if (step && !acc) begin
            if (sh_lim_q == '0) begin
                tc_d  = 1'b1;
                cnt_d = '0;
                if (!sh_rl_q) st_d = DONE;
            end else begin
                unique case (1'b1)
                    is_down: begin
                        if (!at_zero) cnt_d = cnt_q - 1'b1;
                        else begin
                            tc_d = 1'b1;
                            if (sh_rl_q) cnt_d = sh_lim_q;
                            else         st_d  = DONE;
                        end
                    end
                    is_bounce && !dir_q: begin
                        if (!at_top) cnt_d = cnt_q + 1'b1;
                        else begin
                            dir_d = 1'b1;
                            cnt_d = sh_lim_q - 1'b1;
                        end
                    end
                    is_bounce && dir_q: begin
                        if (!at_zero) cnt_d = cnt_q - 1'b1;
                        else begin
                            tc_d = 1'b1;
                            if (sh_rl_q) begin
                                dir_d = 1'b0;
                                cnt_d = WIDTH'(1);
                            end else st_d = DONE;
                        end
                    end
                    default: begin
                        if (!at_top) cnt_d = cnt_q + 1'b1;
                        else begin
                            tc_d = 1'b1;
                            if (sh_rl_q) cnt_d = '0;
                            else         st_d  = DONE;
                        end
                    end
                endcase
            end
        end

        if (acc) begin
            unique case (cmd_op)
                OP_START: begin
                    sh_mode_d = cfg_mode;
                    sh_lim_d  = cfg_limit;
                    sh_div_d  = cfg_div;
                    sh_rl_d   = cfg_reload;
                    div_d     = '0;
                    st_d      = RUN;
                    if (cfg_mode == MODE_DOWN) begin
                        cnt_d = cfg_limit;
                        dir_d = 1'b1;
                    end else begin
                        cnt_d = '0;
                        dir_d = 1'b0;
                    end
                end
                OP_STOP: st_d = IDLE;
                OP_PAUSE: begin
                    if (st_q == RUN)        st_d = PAUSE;
                    else if (st_q == PAUSE) st_d = RUN;
                end
                OP_LOAD: begin
                    if (st_q == IDLE || st_q == PAUSE)
                        cnt_d = (cmd_data > sh_lim_q) ? sh_lim_q : cmd_data;
                end
                default: ;
            endcase
        end
    end

    assign count = cnt_q;
    assign dir   = dir_q;
    assign tc    = tc_q;
    assign state = st_q;
    assign busy  = (st_q == RUN) || (st_q == PAUSE);
    assign done  = (st_q == DONE);

endmodule
